// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared state encoding and sign helpers for the sequential divider
package div_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } div_state_t;

  // Helpers work on the widest legal operand; callers extend in and truncate out.
  localparam int MAX_W = 16;

  // Magnitude of a sign-extended two's-complement value.
  function automatic logic [MAX_W-1:0] abs_w(input logic [MAX_W-1:0] v);
    return v[MAX_W-1] ? (~v + 1'b1) : v;
  endfunction

  // Negate when neg is set; used to restore result signs after magnitude division.
  function automatic logic [MAX_W-1:0] neg_w(input logic [MAX_W-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/div_ctrl.sv
// rtl/div_ctrl.sv - divider sequencing: go acceptance, step counter, busy and result_valid
module div_ctrl
  import div_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic go,
  input  logic div_zero,
  output logic accept,
  output logic finish,
  output logic busy,
  output logic result_valid
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  div_state_t       state;
  logic [CNT_W-1:0] count;

  assign accept = go && (state != S_CALC);
  assign finish = (state == S_CALC) && (count == CNT_W'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      count        <= '0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (go) begin
            state        <= S_CALC;
            // A zero divisor needs no iterations; a single step just loads the fixed result.
            count        <= div_zero ? CNT_W'(1) : CNT_W'(WIDTH);
            busy         <= 1'b1;
            result_valid <= 1'b0;
          end
        end
        S_CALC: begin
          if (count == CNT_W'(1)) begin
            state        <= S_DONE;
            busy         <= 1'b0;
            result_valid <= 1'b1;
          end else begin
            count <= count - 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/seq_divider_n.sv
// rtl/seq_divider_n.sv - restoring divider, one quotient bit per clock, optional signed mode
module seq_divider_n
  import div_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit SIGNED_EN = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             result_valid,
  output logic             busy,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic             accept;
  logic             finish;
  logic             sgn;
  logic [WIDTH-1:0] dvd_mag, dvs_mag;
  logic [WIDTH-1:0] a_reg, q_reg, d_reg, dvd_raw;
  logic             neg_q, neg_r, zero_flag, ovf_flag;
  logic [WIDTH:0]   a_sh, trial;
  logic [WIDTH-1:0] a_next, q_next, q_fix, r_fix;

  div_ctrl #(.WIDTH(WIDTH)) u_ctrl (
    .clk          (clk),
    .reset        (reset),
    .go           (go),
    .div_zero     (divisor == '0),
    .accept       (accept),
    .finish       (finish),
    .busy         (busy),
    .result_valid (result_valid)
  );

  always_comb begin
    sgn     = SIGNED_EN && signed_mode;
    dvd_mag = dividend;
    dvs_mag = divisor;
    if (sgn) begin
      dvd_mag = WIDTH'(abs_w(MAX_W'($signed(dividend))));
      dvs_mag = WIDTH'(abs_w(MAX_W'($signed(divisor))));
    end
    a_sh   = {a_reg, q_reg[WIDTH-1]};
    trial  = a_sh - {1'b0, d_reg};
    // Restoring step: a negative trial keeps the shifted A and shifts in a 0.
    a_next = trial[WIDTH] ? a_sh[WIDTH-1:0] : trial[WIDTH-1:0];
    q_next = {q_reg[WIDTH-2:0], ~trial[WIDTH]};
    q_fix  = WIDTH'(neg_w(MAX_W'(q_next), neg_q));
    r_fix  = WIDTH'(neg_w(MAX_W'(a_next), neg_r));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_reg       <= '0;
      q_reg       <= '0;
      d_reg       <= '0;
      dvd_raw     <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      zero_flag   <= 1'b0;
      ovf_flag    <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else if (accept) begin
      a_reg       <= '0;
      q_reg       <= dvd_mag;
      d_reg       <= dvs_mag;
      dvd_raw     <= dividend;
      neg_q       <= sgn && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
      neg_r       <= sgn && dividend[WIDTH-1];
      zero_flag   <= (divisor == '0);
      ovf_flag    <= sgn && (dividend == MOST_NEG) && (divisor == '1);
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else if (busy) begin
      a_reg <= a_next;
      q_reg <= q_next;
      if (finish) begin
        if (zero_flag) begin
          quotient    <= '1;
          remainder   <= dvd_raw;
          div_by_zero <= 1'b1;
        end else begin
          // Most-negative / -1 wraps naturally: magnitude 2^(W-1) with a positive sign.
          quotient  <= q_fix;
          remainder <= r_fix;
          overflow  <= ovf_flag;
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_divider_n.sv
// tb/tb_seq_divider_n.sv - directed vector bench for seq_divider_n (4-bit signed and 8-bit unsigned)
module tb_seq_divider_n;

  typedef struct {
    logic       sm;
    logic [3:0] dvd;
    logic [3:0] dvs;
    logic [3:0] q;
    logic [3:0] r;
    logic       dz;
    logic       ov;
    int         lat;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic       go4, sm4, v4, b4, dz4, ov4;
  logic [3:0] dvd4, dvs4, q4, r4;
  logic       go8, sm8, v8, b8, dz8, ov8;
  logic [7:0] dvd8, dvs8, q8, r8;

  int n_checks = 0;
  int n_fail   = 0;

  vec_t vecs[11];

  always #5 clk = ~clk;

  seq_divider_n #(.WIDTH(4), .SIGNED_EN(1'b1)) dut4 (
    .clk(clk), .reset(reset), .go(go4), .signed_mode(sm4),
    .dividend(dvd4), .divisor(dvs4), .quotient(q4), .remainder(r4),
    .result_valid(v4), .busy(b4), .div_by_zero(dz4), .overflow(ov4)
  );

  seq_divider_n #(.WIDTH(8), .SIGNED_EN(1'b0)) dut8 (
    .clk(clk), .reset(reset), .go(go8), .signed_mode(sm8),
    .dividend(dvd8), .divisor(dvs8), .quotient(q8), .remainder(r8),
    .result_valid(v8), .busy(b8), .div_by_zero(dz8), .overflow(ov8)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run4(input vec_t v, input string tag);
    sm4  = v.sm;
    dvd4 = v.dvd;
    dvs4 = v.dvs;
    go4  = 1'b1;
    tick;
    go4  = 1'b0;
    chk({tag, " busy@k"}, 16'(b4), 16'd1);
    chk({tag, " valid@k"}, 16'(v4), 16'd0);
    for (int i = 1; i <= v.lat; i++) begin
      tick;
      if (i < v.lat) chk({tag, " busy_mid"}, 16'(b4), 16'd1);
    end
    chk({tag, " quotient"}, 16'(q4), 16'(v.q));
    chk({tag, " remainder"}, 16'(r4), 16'(v.r));
    chk({tag, " valid"}, 16'(v4), 16'd1);
    chk({tag, " busy_end"}, 16'(b4), 16'd0);
    chk({tag, " div_by_zero"}, 16'(dz4), 16'(v.dz));
    chk({tag, " overflow"}, 16'(ov4), 16'(v.ov));
  endtask

  task automatic run8(input logic sm, input logic [7:0] dvd, input logic [7:0] dvs,
                      input logic [7:0] eq, input logic [7:0] er, input bit inject, input string tag);
    sm8  = sm;
    dvd8 = dvd;
    dvs8 = dvs;
    go8  = 1'b1;
    tick;
    go8  = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      if (inject && i == 3) go8 = 1'b1;
      tick;
      go8 = 1'b0;
      if (i < 8) chk({tag, " busy_mid"}, 16'(b8), 16'd1);
    end
    chk({tag, " quotient"}, 16'(q8), 16'(eq));
    chk({tag, " remainder"}, 16'(r8), 16'(er));
    chk({tag, " valid"}, 16'(v8), 16'd1);
    chk({tag, " busy_end"}, 16'(b8), 16'd0);
    chk({tag, " overflow"}, 16'(ov8), 16'd0);
  endtask

  initial begin
    go4 = 0; sm4 = 0; dvd4 = 0; dvs4 = 0;
    go8 = 0; sm8 = 0; dvd8 = 0; dvs8 = 0;

    //            sm    dvd    dvs    q      r      dz    ov    lat
    vecs[0]  = '{1'b0, 4'd13, 4'd3, 4'd4, 4'd1, 1'b0, 1'b0, 4};
    vecs[1]  = '{1'b0, 4'd9,  4'd0, 4'hF, 4'd9, 1'b1, 1'b0, 1};
    vecs[2]  = '{1'b1, 4'h9,  4'd2, 4'hD, 4'hF, 1'b0, 1'b0, 4};
    vecs[3]  = '{1'b1, 4'h8,  4'hF, 4'h8, 4'd0, 1'b0, 1'b1, 4};
    vecs[4]  = '{1'b0, 4'd15, 4'd4, 4'd3, 4'd3, 1'b0, 1'b0, 4};
    vecs[5]  = '{1'b0, 4'd0,  4'd5, 4'd0, 4'd0, 1'b0, 1'b0, 4};
    vecs[6]  = '{1'b0, 4'd15, 4'd1, 4'hF, 4'd0, 1'b0, 1'b0, 4};
    vecs[7]  = '{1'b1, 4'd7,  4'hE, 4'hD, 4'd1, 1'b0, 1'b0, 4};
    vecs[8]  = '{1'b1, 4'h8,  4'd0, 4'hF, 4'h8, 1'b1, 1'b0, 1};
    vecs[9]  = '{1'b0, 4'd8,  4'hF, 4'd0, 4'd8, 1'b0, 1'b0, 4};
    vecs[10] = '{1'b1, 4'd6,  4'd3, 4'd2, 4'd0, 1'b0, 1'b0, 4};

    reset = 1'b1;
    tick;
    tick;
    reset = 1'b0;
    chk("reset quotient", 16'(q4), 16'd0);
    chk("reset remainder", 16'(r4), 16'd0);
    chk("reset valid", 16'(v4), 16'd0);
    chk("reset busy", 16'(b4), 16'd0);
    chk("reset dz", 16'(dz4), 16'd0);
    chk("reset ov", 16'(ov4), 16'd0);
    tick;

    for (int i = 0; i < 11; i++) run4(vecs[i], $sformatf("vec%0d", i));

    repeat (3) tick;
    chk("done_hold valid", 16'(v4), 16'd1);
    chk("done_hold quotient", 16'(q4), 16'd2);

    // Reset arrives on the second calculation edge of 13/3.
    sm4 = 0; dvd4 = 4'd13; dvs4 = 4'd3; go4 = 1'b1;
    tick;
    go4 = 1'b0;
    tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    chk("midreset quotient", 16'(q4), 16'd0);
    chk("midreset remainder", 16'(r4), 16'd0);
    chk("midreset valid", 16'(v4), 16'd0);
    chk("midreset busy", 16'(b4), 16'd0);
    tick;
    chk("midreset stays idle", 16'(b4), 16'd0);
    run4('{1'b0, 4'd6, 4'd2, 4'd3, 4'd0, 1'b0, 1'b0, 4}, "after_reset");

    // Back-to-back with go held; operands change while the first run is in flight.
    sm4 = 0; dvd4 = 4'd15; dvs4 = 4'd4; go4 = 1'b1;
    tick;
    dvd4 = 4'd10; dvs4 = 4'd5;
    repeat (3) begin
      tick;
      chk("b2b first busy", 16'(b4), 16'd1);
    end
    tick;
    chk("b2b first quotient", 16'(q4), 16'd3);
    chk("b2b first remainder", 16'(r4), 16'd3);
    chk("b2b first valid", 16'(v4), 16'd1);
    tick;
    go4 = 1'b0;
    chk("b2b restart busy", 16'(b4), 16'd1);
    chk("b2b restart valid", 16'(v4), 16'd0);
    chk("b2b retained quotient", 16'(q4), 16'd3);
    repeat (3) tick;
    chk("b2b second busy", 16'(b4), 16'd1);
    tick;
    chk("b2b second quotient", 16'(q4), 16'd2);
    chk("b2b second remainder", 16'(r4), 16'd0);
    chk("b2b second valid", 16'(v4), 16'd1);
    chk("b2b second busy_end", 16'(b4), 16'd0);

    run8(1'b0, 8'd255, 8'd16, 8'd15, 8'd15, 1'b1, "w8_255_16");
    run8(1'b0, 8'd200, 8'd7, 8'd28, 8'd4, 1'b0, "w8_200_7");
    run8(1'b1, 8'h80, 8'hFF, 8'd0, 8'h80, 1'b0, "w8_signed_tied_off");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_divider_n.md
Name: seq_divider_n

Overview:
- Parameterised multi-cycle restoring divider; the successor to the fixed 4-bit lab divider.
- Divides a WIDTH-bit dividend by a WIDTH-bit divisor and produces one quotient bit per clock.
- Adds an optional signed mode, divide-by-zero and signed-overflow detection, a Busy flag, and back-to-back operation.
- Sits between switch/key input logic and the hex display decoders in the board top level.

Parameters:
- WIDTH, 4, operand/quotient/remainder width in bits; legal range 2..16.
- SIGNED_EN, 0, 1 makes SignedMode functional; 0 ties signed mode off internally.

Ports:
- Clock  input  1  system clock; all state updates on its rising edge.
- Reset  input  1  synchronous, active-high reset.
- Go  input  1  start request; level sampled each rising edge.
- SignedMode  input  1  1 = two's-complement operands; captured with operands; ignored if SIGNED_EN=0.
- Dividend  input  WIDTH  numerator; captured when Go is accepted.
- Divisor  input  WIDTH  denominator; captured when Go is accepted.
- Quotient  output  WIDTH  registered quotient.
- Remainder  output  WIDTH  registered remainder.
- ResultValid  output  1  high while Quotient/Remainder hold the latest completed result.
- Busy  output  1  high while a division is in progress.
- DivByZero  output  1  latest result was a divide by zero.
- Overflow  output  1  latest result was the signed most-negative / -1 case.

Behaviour:
- Reset (Reset=1 at an edge): all outputs go to 0 and the FSM enters S_IDLE. Reset overrides every other input, including mid-operation; any partial result is discarded.
- FSM states: S_IDLE, S_CALC, S_DONE.
- Go acceptance: Go is accepted at an edge only in S_IDLE or S_DONE.
  - Accepting Go captures Dividend, Divisor and SignedMode, clears ResultValid/DivByZero/Overflow, and sets Busy.
  - In S_CALC, Go is ignored.
- Normal path: accept edge → S_CALC; count = WIDTH.
- Divisor==0 path: accept edge → S_CALC; count = 1.
- Each S_CALC edge:
  - Shift {A, Q} left by 1.
  - Trial-subtract: A_trial = A - D on WIDTH+1 bits.
  - If A_trial is negative, restore A and shift in q=0; otherwise A = A_trial and shift in q=1.
  - count decrements; at count==1 the output registers load and the state moves to S_DONE.
- Latency: Go accepted at edge k → ResultValid=1 and Busy=0 after edge k+WIDTH. The divide-by-zero path completes after edge k+1.
- Signed mode (SIGNED_EN=1 and captured SignedMode=1):
  - Operands are converted to magnitudes at capture.
  - Result signs are fixed at completion, giving truncation toward zero.
  - Quotient sign = sign(Dividend) XOR sign(Divisor); Remainder sign = sign(Dividend).
  - Invariant: Dividend == Quotient*Divisor + Remainder.
- Divide by zero:
  - Quotient = all ones; Remainder = captured Dividend unchanged; DivByZero=1.
  - Signedness does not alter this result.
- Signed overflow (Dividend = -2^(WIDTH-1), Divisor = -1, signed):
  - Quotient = -2^(WIDTH-1) (wrapped); Remainder = 0; Overflow=1.
  - Full WIDTH-cycle latency still applies.
- Unsigned mode: no overflow is possible; Overflow stays 0.
- S_DONE: outputs hold and ResultValid stays 1 indefinitely.
  - Go=1 in S_DONE starts a new operation on the same edge, so back-to-back runs need no idle cycle.
  - Quotient/Remainder retain their previous values until the next completion.
- Go held high continuously: a new division starts each time the FSM reaches S_DONE. Dividend/Divisor changes during S_CALC have no effect.
- Widths:
  - A and trial subtraction: WIDTH+1 bits.
  - Counter: $clog2(WIDTH+1) bits.
  - Magnitude of -2^(WIDTH-1) is handled as a WIDTH-bit unsigned value.

Decomposition:
- Shared package div_pkg holds:
  - state encoding localparams S_IDLE/S_CALC/S_DONE;
  - function abs_w (two's-complement magnitude);
  - function neg_w (conditional negate).
- One natural sub-module: div_ctrl (FSM, counter, Busy/ResultValid, Go acceptance).
- The datapath (shift/subtract/restore, sign fix-up, output registers) stays in seq_divider_n.

Test Plan:
- Unsigned WIDTH=4: Dividend=13, Divisor=3, Go pulsed 1 cycle at edge k → at k+4: Quotient=4, Remainder=1, ResultValid=1, Busy=0.
- Divide by zero, WIDTH=4: Dividend=9, Divisor=0 → at k+1: Quotient=4'hF, Remainder=9, DivByZero=1, Overflow=0.
- Signed, SIGNED_EN=1, WIDTH=4:
  - -7/2 → Quotient=4'b1101 (-3), Remainder=4'b1111 (-1).
  - -8/-1 → Quotient=4'b1000, Remainder=0, Overflow=1.
- Reset mid-operation: Go accepted, Reset=1 on the 2nd S_CALC edge → next edge: all outputs 0, S_IDLE. A later 6/2 returns Quotient=3, Remainder=0 four cycles after Go.
- Back-to-back with Go held high, WIDTH=4: 15/4 then operands changed to 10/5 → results 3 r3, then 2 r0, with no idle cycle between. An operand change during S_CALC does not affect the in-flight result.
- WIDTH=8: 255/16 → Quotient=15, Remainder=15 at k+8. Go pulse during S_CALC is ignored; Busy stays 1 until completion.
